// File: rtl/aux_reg_ctrl.sv
// aux_reg_ctrl: drives the 6-bit aux counter register (data/enable/clear).
// It clears the register on start and then steps it by one per accepted step request.
// When the fed-back count reaches the latched limit, it pulses done.
module aux_reg_ctrl #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start_i,
   input  logic [WIDTH-1:0] limit_i,
   input  logic             step_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] aux_fb_i,
   output logic [WIDTH-1:0] aux_d_o,
   output logic             aux_en_o,
   output logic             aux_clr_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] limit_q, limit_d;

   // The data path is always fb+1. The wrap to 0 is harmless because enable is
   // never raised once fb has reached the limit.
   assign aux_d_o = aux_fb_i + WIDTH'(1);

   // Next-state and output decode; clear always wins over enable
   always_comb begin
      state_d   = state_q;
      limit_d   = limit_q;
      aux_en_o  = 1'b0;
      aux_clr_o = 1'b0;
      busy_o    = (state_q != S_IDLE);
      done_o    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               limit_d = limit_i;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            aux_clr_o = 1'b1;
            state_d   = abort_i ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (abort_i) begin
               aux_clr_o = 1'b1;
               state_d   = S_IDLE;
            end else if (aux_fb_i >= limit_q) begin
               // also covers a corrupted count above the limit
               state_d = S_DONE;
            end else if (step_i) begin
               aux_en_o = 1'b1;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched limit registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         limit_q <= '0;
      end else begin
         state_q <= state_d;
         limit_q <= limit_d;
      end
   end

endmodule

// File: tb/tb_aux_reg_ctrl.sv
// Directed bench for aux_reg_ctrl, including a behavioural aux counter register.
// Cycle c=0 is the cycle in which start_i is presented while the DUT is idle.
module tb_aux_reg_ctrl;
   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         start_i = 1'b0;
   logic         step_i = 1'b0;
   logic         abort_i = 1'b0;
   logic [W-1:0] limit_i = '0;
   logic [W-1:0] aux_fb_i;
   logic [W-1:0] aux_d_o;
   logic         aux_en_o, aux_clr_o, busy_o, done_o;
   logic [3:0]   exp;
   int           vectors = 0;
   int           miscompares = 0;

   always #5 clk = ~clk;

   aux_reg_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rstn(rstn), .start_i(start_i), .limit_i(limit_i),
      .step_i(step_i), .abort_i(abort_i), .aux_fb_i(aux_fb_i),
      .aux_d_o(aux_d_o), .aux_en_o(aux_en_o), .aux_clr_o(aux_clr_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   // aux counter register: same reset net, sync clear has priority over load
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)          aux_fb_i <= '0;
      else if (aux_clr_o) aux_fb_i <= '0;
      else if (aux_en_o)  aux_fb_i <= aux_d_o;
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      vectors++;
      if ({busy_o, done_o, aux_en_o, aux_clr_o} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctl got %b want 0000", {busy_o, done_o, aux_en_o, aux_clr_o});
      end
      vectors++;
      if (aux_d_o !== 6'd1 || aux_fb_i !== 6'd0) begin
         miscompares++;
         $display("FAIL reset_data got d=%0d fb=%0d want d=1 fb=0", aux_d_o, aux_fb_i);
      end
      next_cycle;
      rstn = 1'b1;
      step_i = 1'b1;
      abort_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if ({busy_o, done_o, aux_en_o, aux_clr_o} !== 4'b0000 || aux_fb_i !== 6'd0) begin
            miscompares++;
            $display("FAIL idle_ignore c=%0d got %b fb=%0d want 0000 fb=0", c,
                     {busy_o, done_o, aux_en_o, aux_clr_o}, aux_fb_i);
         end
         next_cycle;
      end
      step_i = 1'b0;
      abort_i = 1'b0;
   endtask

   task automatic test_limit3;
      limit_i = 6'd3;
      step_i = 1'b1;
      for (int c = 0; c < 9; c++) begin
         start_i = (c == 0);
         #1;
         exp = {c >= 1 && c <= 6, c == 6, c >= 2 && c <= 4, c == 1};
         vectors++;
         if ({busy_o, done_o, aux_en_o, aux_clr_o} !== exp) begin
            miscompares++;
            $display("FAIL limit3_ctl c=%0d got %b want %b", c, {busy_o, done_o, aux_en_o, aux_clr_o}, exp);
         end
         if (c >= 2 && c <= 4) begin
            vectors++;
            if (aux_d_o !== W'(c - 1)) begin
               miscompares++;
               $display("FAIL limit3_d c=%0d got %0d want %0d", c, aux_d_o, c - 1);
            end
         end
         if (c == 5) begin
            vectors++;
            if (aux_fb_i !== 6'd3) begin
               miscompares++;
               $display("FAIL limit3_fb got %0d want 3", aux_fb_i);
            end
         end
         next_cycle;
      end
      step_i = 1'b0;
   endtask

   task automatic test_limit0;
      limit_i = 6'd0;
      step_i = 1'b1;
      for (int c = 0; c < 7; c++) begin
         start_i = (c == 0);
         #1;
         exp = {c >= 1 && c <= 3, c == 3, 1'b0, c == 1};
         vectors++;
         if ({busy_o, done_o, aux_en_o, aux_clr_o} !== exp || (c >= 2 && aux_fb_i !== 6'd0)) begin
            miscompares++;
            $display("FAIL limit0 c=%0d got %b fb=%0d want %b fb=0", c,
                     {busy_o, done_o, aux_en_o, aux_clr_o}, aux_fb_i, exp);
         end
         next_cycle;
      end
      step_i = 1'b0;
   endtask

   task automatic test_limit63;
      int errs;
      int ens;
      errs = 0;
      ens = 0;
      limit_i = 6'd63;
      step_i = 1'b1;
      for (int c = 0; c < 70; c++) begin
         start_i = (c == 0);
         #1;
         exp = {c >= 1 && c <= 66, c == 66, c >= 2 && c <= 64, c == 1};
         if ({busy_o, done_o, aux_en_o, aux_clr_o} !== exp) errs++;
         if (aux_en_o) begin
            ens++;
            if (aux_d_o !== W'(c - 1) || aux_d_o === 6'd0) errs++;
         end
         if (c >= 65 && aux_fb_i !== 6'd63) errs++;
         next_cycle;
      end
      step_i = 1'b0;
      vectors++;
      if (errs != 0) begin
         miscompares++;
         $display("FAIL limit63_seq got %0d bad cycles want 0", errs);
      end
      vectors++;
      if (ens != 63 || aux_fb_i !== 6'd63) begin
         miscompares++;
         $display("FAIL limit63_count got en=%0d fb=%0d want en=63 fb=63", ens, aux_fb_i);
      end
   endtask

   task automatic test_step_toggle;
      int errs;
      errs = 0;
      limit_i = 6'd5;
      for (int c = 0; c < 15; c++) begin
         start_i = (c == 0);
         step_i = (c % 2 == 0);
         #1;
         exp = {c >= 1 && c <= 12, c == 12, c inside {2, 4, 6, 8, 10}, c == 1};
         if ({busy_o, done_o, aux_en_o, aux_clr_o} !== exp) begin
            errs++;
            $display("FAIL toggle_ctl c=%0d got %b want %b", c, {busy_o, done_o, aux_en_o, aux_clr_o}, exp);
         end
         if (aux_en_o && aux_d_o !== W'(c / 2)) errs++;
         next_cycle;
      end
      step_i = 1'b0;
      vectors++;
      if (errs != 0 || aux_fb_i !== 6'd5) begin
         miscompares++;
         $display("FAIL toggle_result got errs=%0d fb=%0d want errs=0 fb=5", errs, aux_fb_i);
      end
   endtask

   task automatic test_abort;
      limit_i = 6'd10;
      step_i = 1'b1;
      for (int c = 0; c < 11; c++) begin
         start_i = (c == 0);
         abort_i = (c == 6);
         #1;
         if (c == 6) begin
            vectors++;
            if (aux_fb_i !== 6'd4) begin
               miscompares++;
               $display("FAIL abort_fb_pre got %0d want 4", aux_fb_i);
            end
         end
         exp = {c >= 1 && c <= 6, 1'b0, c >= 2 && c <= 5, c == 1 || c == 6};
         vectors++;
         if ({busy_o, done_o, aux_en_o, aux_clr_o} !== exp) begin
            miscompares++;
            $display("FAIL abort_ctl c=%0d got %b want %b", c, {busy_o, done_o, aux_en_o, aux_clr_o}, exp);
         end
         next_cycle;
      end
      abort_i = 1'b0;
      step_i = 1'b0;
      vectors++;
      if (aux_fb_i !== 6'd0) begin
         miscompares++;
         $display("FAIL abort_fb_post got %0d want 0", aux_fb_i);
      end
   endtask

   task automatic test_back_to_back;
      // start+abort together in idle: start wins; start held while busy with a new limit is ignored
      step_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         start_i = 1'b1;
         abort_i = (c == 0);
         limit_i = (c == 0) ? 6'd2 : 6'd7;
         #1;
         if (c <= 5) begin
            exp = {c >= 1, c == 5, c == 2 || c == 3, c == 1};
            vectors++;
            if ({busy_o, done_o, aux_en_o, aux_clr_o} !== exp) begin
               miscompares++;
               $display("FAIL b2b_ctl c=%0d got %b want %b", c, {busy_o, done_o, aux_en_o, aux_clr_o}, exp);
            end
         end
         if (c == 5) begin
            start_i = 1'b0;
            vectors++;
            if (aux_fb_i !== 6'd2) begin
               miscompares++;
               $display("FAIL b2b_fb got %0d want 2", aux_fb_i);
            end
         end
         if (c == 5) abort_i = 1'b1;
         next_cycle;
         if (c == 5) break;
      end
      abort_i = 1'b0;
      start_i = 1'b0;
      step_i = 1'b0;
      next_cycle;
   endtask

   task automatic test_reset_midrun;
      limit_i = 6'd2;
      step_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         start_i = (c == 0) || (c == 2);
         next_cycle;
      end
      start_i = 1'b0;
      vectors++;
      if (aux_fb_i !== 6'd1 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL midrun_pre got fb=%0d busy=%b want fb=1 busy=1", aux_fb_i, busy_o);
      end
      rstn = 1'b0;
      #1;
      vectors++;
      if ({busy_o, done_o, aux_en_o, aux_clr_o} !== 4'b0000 || aux_fb_i !== 6'd0 || aux_d_o !== 6'd1) begin
         miscompares++;
         $display("FAIL midrun_reset got %b fb=%0d d=%0d want 0000 fb=0 d=1",
                  {busy_o, done_o, aux_en_o, aux_clr_o}, aux_fb_i, aux_d_o);
      end
      next_cycle;
      rstn = 1'b1;
      next_cycle;
      limit_i = 6'd1;
      for (int c = 0; c < 7; c++) begin
         start_i = (c == 0);
         #1;
         exp = {c >= 1 && c <= 4, c == 4, c == 2, c == 1};
         vectors++;
         if ({busy_o, done_o, aux_en_o, aux_clr_o} !== exp) begin
            miscompares++;
            $display("FAIL fresh_ctl c=%0d got %b want %b", c, {busy_o, done_o, aux_en_o, aux_clr_o}, exp);
         end
         next_cycle;
      end
      step_i = 1'b0;
      vectors++;
      if (aux_fb_i !== 6'd1) begin
         miscompares++;
         $display("FAIL fresh_fb got %0d want 1", aux_fb_i);
      end
   endtask

   initial begin
      test_reset;
      test_limit3;
      test_limit0;
      test_limit63;
      test_step_toggle;
      test_abort;
      test_back_to_back;
      test_reset_midrun;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
